// File: rtl/uart_rx_param.sv
// Parameterized UART receiver: oversampled start detect, 3-sample majority vote per bit,
// optional parity, 1/1.5/2 stop intervals, held output word with ready/valid and overrun.
module uart_rx_param #(
    parameter int DBIT    = 8,
    parameter int OS      = 16,
    parameter int SB_TICK = 16,
    parameter int PAR_EN  = 0,
    parameter int PAR_ODD = 0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            rx,
    input  logic            s_tick,
    input  logic            rx_ready,
    output logic [DBIT-1:0] dout,
    output logic            rx_valid,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            parity_err,
    output logic            break_det,
    output logic            overrun
);
    localparam int SMAX = (OS > SB_TICK) ? OS : SB_TICK;
    localparam int SW   = $clog2(SMAX);
    localparam int NW   = $clog2(DBIT);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] START   = 3'd1;
    localparam logic [2:0] DATA    = 3'd2;
    localparam logic [2:0] PARITY  = 3'd3;
    localparam logic [2:0] STOP    = 3'd4;
    localparam logic [2:0] WAIT_HI = 3'd5;

    localparam logic [SW-1:0] S_HALF = SW'(OS/2 - 1);
    localparam logic [SW-1:0] S_M3   = SW'(OS - 3);
    localparam logic [SW-1:0] S_M2   = SW'(OS - 2);
    localparam logic [SW-1:0] S_LAST = SW'(OS - 1);
    localparam logic [SW-1:0] S_END  = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
    localparam logic          ODD    = (PAR_ODD != 0);

    logic            rx_meta, rxs;
    logic [2:0]      state;
    logic [SW-1:0]   s;
    logic [NW-1:0]   n;
    logic [DBIT-1:0] sh;
    logic            v0, v1;
    logic            stop_q, par_q, pe_q;

    logic vote, frame_end, stop_now, fe_new, brk_new, pe_new;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // Two earlier samples plus the live one form the vote at s==OS-1.
    always_comb begin
        vote      = (v0 & v1) | (v0 & rxs) | (v1 & rxs);
        frame_end = (state == STOP) && s_tick && (s == S_END);
        stop_now  = (s == S_LAST) ? vote : stop_q;
        fe_new    = !stop_now;
        brk_new   = (sh == '0) && !par_q && !stop_now;
        pe_new    = (PAR_EN != 0) ? pe_q : 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            s      <= '0;
            n      <= '0;
            sh     <= '0;
            v0     <= 1'b0;
            v1     <= 1'b0;
            stop_q <= 1'b0;
            par_q  <= 1'b0;
            pe_q   <= 1'b0;
        end else begin
            if (s_tick && (state == DATA || state == PARITY || state == STOP)) begin
                if (s == S_M3) v0 <= rxs;
                if (s == S_M2) v1 <= rxs;
            end
            case (state)
                IDLE: if (!rxs) begin
                    state <= START;
                    s     <= '0;
                end
                START: if (s_tick) begin
                    if (s == S_HALF) begin
                        if (rxs) state <= IDLE;
                        else begin
                            state <= DATA;
                            s     <= '0;
                            n     <= '0;
                            par_q <= 1'b0;
                        end
                    end else s <= s + 1'b1;
                end
                DATA: if (s_tick) begin
                    if (s == S_LAST) begin
                        sh <= {vote, sh[DBIT-1:1]};
                        s  <= '0;
                        if (n == N_LAST) state <= (PAR_EN != 0) ? PARITY : STOP;
                        else n <= n + 1'b1;
                    end else s <= s + 1'b1;
                end
                PARITY: if (s_tick) begin
                    if (s == S_LAST) begin
                        par_q <= vote;
                        pe_q  <= ((^sh) ^ vote) != ODD;
                        s     <= '0;
                        state <= STOP;
                    end else s <= s + 1'b1;
                end
                // The stop vote at OS-1 does not restart s; the interval runs to SB_TICK-1.
                STOP: if (s_tick) begin
                    if (s == S_LAST) stop_q <= vote;
                    if (s == S_END) begin
                        s     <= '0;
                        state <= fe_new ? WAIT_HI : IDLE;
                    end else s <= s + 1'b1;
                end
                WAIT_HI: if (rxs) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout         <= '0;
            rx_valid     <= 1'b0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
            parity_err   <= 1'b0;
            break_det    <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            rx_done_tick <= frame_end;
            if (frame_end) begin
                if (!rx_valid || rx_ready) begin
                    dout       <= sh;
                    frame_err  <= fe_new;
                    parity_err <= pe_new;
                    break_det  <= brk_new;
                    rx_valid   <= 1'b1;
                    if (rx_valid) overrun <= 1'b0;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
                overrun  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: 8N1 instance and 7-bit odd-parity 1.5-stop instance.
module tb_uart_rx_param;
    localparam int OS     = 16;
    localparam int TDIV   = 4;
    localparam int BITCLK = OS * TDIV;

    logic clk = 1'b0, reset_n = 1'b0, s_tick = 1'b0;
    logic rx0 = 1'b1, gl0 = 1'b0, rx1 = 1'b1, rdy0 = 1'b1, rdy1 = 1'b1;
    logic [7:0] dout0;
    logic [6:0] dout1;
    logic valid0, done0, fe0, pe0, bk0, ov0;
    logic valid1, done1, fe1, pe1, bk1, ov1;
    int   tcnt = 0;
    int   checks = 0, errors = 0;

    int   dc0 = 0, vc0 = 0, dc1 = 0;
    logic [7:0] cd0 = '0;
    logic [6:0] cd1 = '0;
    logic cfe0, cpe0, cbk0, cov0, cv0, cfe1, cpe1, cbk1;

    uart_rx_param #(.DBIT(8), .OS(OS), .SB_TICK(16), .PAR_EN(0), .PAR_ODD(0)) u0 (
        .clk(clk), .reset_n(reset_n), .rx(rx0 ^ gl0), .s_tick(s_tick), .rx_ready(rdy0),
        .dout(dout0), .rx_valid(valid0), .rx_done_tick(done0), .frame_err(fe0),
        .parity_err(pe0), .break_det(bk0), .overrun(ov0));

    uart_rx_param #(.DBIT(7), .OS(OS), .SB_TICK(24), .PAR_EN(1), .PAR_ODD(1)) u1 (
        .clk(clk), .reset_n(reset_n), .rx(rx1), .s_tick(s_tick), .rx_ready(rdy1),
        .dout(dout1), .rx_valid(valid1), .rx_done_tick(done1), .frame_err(fe1),
        .parity_err(pe1), .break_det(bk1), .overrun(ov1));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        tcnt   <= (tcnt == TDIV-1) ? 0 : tcnt + 1;
        s_tick <= (tcnt == TDIV-1);
    end

    always @(negedge clk) begin
        if (done0) begin
            dc0 <= dc0 + 1; cd0 <= dout0; cv0 <= valid0;
            cfe0 <= fe0; cpe0 <= pe0; cbk0 <= bk0; cov0 <= ov0;
        end
        if (valid0) vc0 <= vc0 + 1;
        if (done1) begin
            dc1 <= dc1 + 1; cd1 <= dout1; cfe1 <= fe1; cpe1 <= pe1; cbk1 <= bk1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send0(input logic [7:0] d);
        rx0 = 1'b0;
        repeat (BITCLK) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx0 = d[i];
            repeat (BITCLK) @(negedge clk);
        end
        rx0 = 1'b1;
        repeat (BITCLK * 3) @(negedge clk);
    endtask

    task automatic send1(input logic [6:0] d, input logic p);
        rx1 = 1'b0;
        repeat (BITCLK) @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            rx1 = d[i];
            repeat (BITCLK) @(negedge clk);
        end
        rx1 = p;
        repeat (BITCLK) @(negedge clk);
        rx1 = 1'b1;
        repeat (BITCLK * 3) @(negedge clk);
    endtask

    // One-tick inversion of data bit 3 aimed at the s==OS-2 sample.
    task automatic glitch_bit3(output logic found);
        found = 1'b0;
        for (int c = 0; c < BITCLK * 12 && !found; c++) begin
            @(negedge clk);
            if (u0.state == 3'd2 && u0.n == 3'd3 && u0.s == 4'd13 && s_tick) found = 1'b1;
        end
        if (found) begin
            gl0 = 1'b1;
            repeat (4) @(negedge clk);
            gl0 = 1'b0;
        end
    endtask

    initial begin
        int d, v;
        logic found;
        logic [7:0] vec [4] = '{8'h3C, 8'hFF, 8'h00, 8'h81};

        repeat (5) @(negedge clk);
        chk("rst_valid", valid0, 0);
        chk("rst_dout", dout0, 0);
        chk("rst_done", done0, 0);
        chk("rst_flags", {fe0, pe0, bk0, ov0}, 0);
        chk("rst_state", u0.state, 0);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);

        d = dc0; v = vc0;
        send0(8'hA5);
        chk("a5_done", dc0 - d, 1);
        chk("a5_dout", cd0, 8'hA5);
        chk("a5_valid", cv0, 1);
        chk("a5_vcyc", vc0 - v, 1);
        chk("a5_flags", {cfe0, cpe0, cbk0, cov0}, 0);

        for (int i = 0; i < 4; i++) begin
            d = dc0;
            send0(vec[i]);
            chk("vec_done", dc0 - d, 1);
            chk("vec_dout", cd0, vec[i]);
            chk("vec_flags", {cfe0, cpe0, cbk0, cov0}, 0);
        end

        // 0x35 has four ones: odd parity wants p=1, so p=0 is bad.
        send1(7'h35, 1'b0);
        chk("p35_done", dc1, 1);
        chk("p35_dout", cd1, 7'h35);
        chk("p35_perr", cpe1, 1);
        chk("p35_ferr", cfe1, 0);
        send1(7'h35, 1'b1);
        chk("p35ok_perr", cpe1, 0);
        chk("p35ok_dout", cd1, 7'h35);
        send1(7'h7F, 1'b0);
        chk("p7f_perr", cpe1, 0);
        chk("p7f_flags", {cfe1, cbk1}, 0);

        d = dc0;
        rx0 = 1'b0;
        repeat ((OS/2 - 2) * TDIV) @(negedge clk);
        rx0 = 1'b1;
        repeat (BITCLK * 12) @(negedge clk);
        chk("glitch_start_done", dc0 - d, 0);
        chk("glitch_start_valid", valid0, 0);

        d = dc0;
        rx0 = 1'b0;
        repeat (BITCLK * 20) @(negedge clk);
        chk("brk_done", dc0 - d, 1);
        chk("brk_dout", cd0, 0);
        chk("brk_ferr", cfe0, 1);
        chk("brk_det", cbk0, 1);
        rx0 = 1'b1;
        repeat (BITCLK * 12) @(negedge clk);
        chk("brk_no_second", dc0 - d, 1);
        send0(8'h5A);
        chk("after_brk_dout", cd0, 8'h5A);
        chk("after_brk_flags", {cfe0, cbk0}, 0);

        rdy0 = 1'b0;
        d = dc0;
        send0(8'h11);
        send0(8'h22);
        chk("ovr_done", dc0 - d, 2);
        chk("ovr_dout", dout0, 8'h11);
        chk("ovr_flag", ov0, 1);
        chk("ovr_valid", valid0, 1);
        rdy0 = 1'b1;
        @(negedge clk);
        chk("ovr_clr_valid", valid0, 0);
        chk("ovr_clr_flag", ov0, 0);

        fork
            send0(8'hA5);
            glitch_bit3(found);
        join
        chk("vote_found", found, 1);
        chk("vote_dout", cd0, 8'hA5);

        rdy0 = 1'b0;
        send0(8'h44);
        chk("pre_rst_valid", valid0, 1);
        rx0 = 1'b0;
        found = 1'b0;
        for (int c = 0; c < BITCLK * 4 && !found; c++) begin
            @(negedge clk);
            if (u0.state == 3'd2) found = 1'b1;
        end
        chk("reach_data", found, 1);
        repeat (2 * BITCLK) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", valid0, 0);
        chk("mid_rst_dout", dout0, 0);
        chk("mid_rst_flags", {fe0, pe0, bk0, ov0, done0}, 0);
        chk("mid_rst_state", u0.state, 0);
        rx0 = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        rdy0 = 1'b1;
        d = dc0;
        repeat (BITCLK * 12) @(negedge clk);
        chk("post_rst_done", dc0 - d, 0);
        chk("post_rst_valid", valid0, 0);
        send0(8'h96);
        chk("post_rst_dout", cd0, 8'h96);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
